// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding, default latencies.
// The optional build macro ALU_ARB_FIXED_PRIO_EN is consumed by alu_arb_rr2.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_FORWARD = 3'b000,
    OP_ADD     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_MULT    = 3'b100,
    OP_SL      = 3'b101,
    OP_SRA     = 3'b110,
    OP_ROR     = 3'b111
  } alu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_LAT_SHORT = 1;
  localparam int DEF_LAT_LONG  = 2;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic isShortOp(input logic [2:0] sel);
    return (sel == OP_FORWARD) || (sel == OP_AND) || (sel == OP_OR);
  endfunction

  // A latency of zero would never leave BUSY, so it is promoted to one cycle.
  function automatic cnt_t clampLat(input int lat);
    return (lat < 1) ? cnt_t'(1) : cnt_t'(lat);
  endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-input grant logic with a last-served register (round-robin on ties).
// Defining ALU_ARB_FIXED_PRIO_EN makes A always win ties and removes the register.
module alu_arb_rr2 (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_update,
  output logic o_grant_a,
  output logic o_grant_b
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic w_unused;
  assign w_unused  = &{1'b0, i_clk, i_reset_n, i_update};
  assign o_grant_a = i_a_valid;
  assign o_grant_b = i_b_valid & ~i_a_valid;

`else

  // High when B was the most recently served port; reset value lets A win the first tie.
  logic r_last_b;

  assign o_grant_a = i_a_valid & (~i_b_valid | r_last_b);
  assign o_grant_b = i_b_valid & (~i_a_valid | ~r_last_b);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_last_b <= 1'b1;
    end else if (i_update) begin
      r_last_b <= o_grant_b;
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU with opcode-dependent latency.
// Tie-break policy is selected in alu_arb_rr2 via ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int LAT_SHORT = DEF_LAT_SHORT,
  parameter int LAT_LONG  = DEF_LAT_LONG
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_a_valid,
  input  logic       i_b_valid,
  output logic       o_a_ready,
  output logic       o_b_ready,
  input  logic [2:0] i_a_select,
  input  logic [2:0] i_b_select,
  input  logic [7:0] i_a_data1,
  input  logic [7:0] i_a_data2,
  input  logic [7:0] i_b_data1,
  input  logic [7:0] i_b_data2,
  output logic [7:0] o_alu_data1,
  output logic [7:0] o_alu_data2,
  output logic [2:0] o_alu_select,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_zero,
  output logic       o_a_rsp_valid,
  output logic       o_b_rsp_valid,
  output logic [7:0] o_rsp_result,
  output logic       o_rsp_zero
);

  localparam cnt_t LS = clampLat(LAT_SHORT);
  localparam cnt_t LL = clampLat(LAT_LONG);

  logic [1:0] r_state;
  cnt_t       r_cnt;
  logic       r_served_b;
  logic [7:0] r_alu_data1;
  logic [7:0] r_alu_data2;
  logic [2:0] r_alu_select;
  logic [7:0] r_rsp_result;
  logic       r_rsp_zero;

  logic       w_idle;
  logic       w_grant_a;
  logic       w_grant_b;
  logic       w_accept;
  logic [2:0] w_sel;

  alu_arb_rr2 u_rr2 (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_a_valid (i_a_valid),
    .i_b_valid (i_b_valid),
    .i_update  (w_accept),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // Handshake and strobes are forced low during reset even before the reset edge lands.
  assign w_idle        = (r_state == ST_IDLE);
  assign o_a_ready     = i_reset_n & w_idle & i_a_valid & w_grant_a;
  assign o_b_ready     = i_reset_n & w_idle & i_b_valid & w_grant_b;
  assign w_accept      = o_a_ready | o_b_ready;
  assign w_sel         = w_grant_a ? i_a_select : i_b_select;
  assign o_a_rsp_valid = i_reset_n & (r_state == ST_RESP) & ~r_served_b;
  assign o_b_rsp_valid = i_reset_n & (r_state == ST_RESP) & r_served_b;

  assign o_alu_data1  = r_alu_data1;
  assign o_alu_data2  = r_alu_data2;
  assign o_alu_select = r_alu_select;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_served_b   <= 1'b0;
      r_alu_data1  <= '0;
      r_alu_data2  <= '0;
      r_alu_select <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_served_b   <= w_grant_b;
            r_alu_data1  <= w_grant_a ? i_a_data1 : i_b_data1;
            r_alu_data2  <= w_grant_a ? i_a_data2 : i_b_data2;
            r_alu_select <= w_sel;
            r_cnt        <= isShortOp(w_sel) ? LS : LL;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The last BUSY cycle captures the ALU output while operands are still stable.
          if (r_cnt <= cnt_t'(1)) begin
            r_rsp_result <= i_alu_result;
            r_rsp_zero   <= i_alu_zero;
            r_cnt        <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - cnt_t'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
